// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's CPU, DMA and memory-port signals.
// slave: the arbiter's view. master: the environment (masters + memory).
interface mem_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_width;
  logic        cpu_write;
  logic        cpu_done;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [1:0]  dma_width;
  logic        dma_write;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        dma_lock;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_drive;
  logic [1:0]  mem_width;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ok;
  logic [31:0] mem_rdata;
  logic        owner;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_width, cpu_write,
    output cpu_done, cpu_rdata,
    input  dma_req, dma_addr, dma_wdata, dma_width, dma_write, dma_lock,
    output dma_done, dma_rdata,
    output mem_addr, mem_wdata, mem_drive, mem_width, mem_read, mem_write,
    input  mem_ok, mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_width, cpu_write,
    input  cpu_done, cpu_rdata,
    output dma_req, dma_addr, dma_wdata, dma_width, dma_write, dma_lock,
    input  dma_done, dma_rdata,
    input  mem_addr, mem_wdata, mem_drive, mem_width, mem_read, mem_write,
    output mem_ok, mem_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) arbiter and three-phase sequencer for the memory
// CPU-side port: IDLE (strobes low) -> FIRST (mem_ok ignored) -> HOLD
// (wait for mem_ok). DMA has priority; the CPU is forced one slot after
// STARVE_LIMIT consecutive DMA completions unless the DMA holds its lock.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic        owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        is_write_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;
  logic [3:0]  starve_cnt;
  logic        cpu_win;
  logic        complete;

  // Saturating increment of the CPU starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  // Winner selection: forced CPU slot, else DMA priority, else CPU.
  always_comb begin
    cpu_win = bus.cpu_req &&
              (!bus.dma_req || (starve_cnt == LIMIT && !bus.dma_lock));
  end

  // Completion is decoded so done lands in the same cycle mem_ok is seen;
  // a reset in that cycle aborts the access without a done pulse.
  assign complete      = (state == HOLD) && bus.mem_ok && !rst;
  assign bus.cpu_done  = complete && !owner_q;
  assign bus.dma_done  = complete &&  owner_q;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_width = width_q;
  assign bus.mem_read  = read_q;
  assign bus.mem_write = write_q;
  assign bus.mem_drive = write_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

  // Access sequencer: grant and latch in IDLE, strobe through FIRST/HOLD,
  // capture read data and update starvation count on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      is_write_q  <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      starve_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            if (cpu_win) begin
              owner_q    <= 1'b0;
              addr_q     <= bus.cpu_addr;
              wdata_q    <= bus.cpu_wdata;
              width_q    <= bus.cpu_width;
              is_write_q <= bus.cpu_write;
              read_q     <= !bus.cpu_write;
              write_q    <= bus.cpu_write;
            end else begin
              owner_q    <= 1'b1;
              addr_q     <= bus.dma_addr;
              wdata_q    <= bus.dma_wdata;
              width_q    <= bus.dma_width;
              is_write_q <= bus.dma_write;
              read_q     <= !bus.dma_write;
              write_q    <= bus.dma_write;
            end
            state <= FIRST;
          end
        end
        FIRST: begin
          state <= HOLD;
        end
        HOLD: begin
          if (bus.mem_ok) begin
            if (!is_write_q) begin
              if (owner_q) dma_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
            if (!owner_q)         starve_cnt <= '0;
            else if (bus.cpu_req) starve_cnt <= sat_inc(starve_cnt);
            else                  starve_cnt <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed cycle patterns.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An access is "in flight" from its grant; phase counts cycles since the
  // grant cycle. Strobes are high while in flight; it may finish from
  // phase 2 onward on a cycle with mem_ok high.
  bit          m_valid = 0;
  bit          m_busy  = 0;
  int          m_phase = 0;
  bit          m_own   = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0]  m_width = '0;
  bit          m_wr    = 0;
  logic [31:0] m_crd   = '0;
  logic [31:0] m_drd   = '0;
  int          m_starve = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_busy = 0; m_phase = 0; m_own = 0; m_addr = '0;
      m_wdata = '0; m_width = '0; m_wr = 0; m_crd = '0; m_drd = '0;
      m_starve = 0;
    end else if (m_busy) begin
      if (m_phase >= 2 && bus.mem_ok) begin
        m_busy = 0;
        if (!m_wr) begin
          if (m_own) m_drd = bus.mem_rdata;
          else       m_crd = bus.mem_rdata;
        end
        if (!m_own)           m_starve = 0;
        else if (bus.cpu_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        else                  m_starve = 0;
      end else begin
        m_phase++;
      end
    end else if (bus.cpu_req || bus.dma_req) begin
      bit cpu_turn;
      cpu_turn = bus.cpu_req &&
                 (!bus.dma_req || (m_starve == LIMIT && !bus.dma_lock));
      m_own   = !cpu_turn;
      m_addr  = cpu_turn ? bus.cpu_addr  : bus.dma_addr;
      m_wdata = cpu_turn ? bus.cpu_wdata : bus.dma_wdata;
      m_width = cpu_turn ? bus.cpu_width : bus.dma_width;
      m_wr    = cpu_turn ? bus.cpu_write : bus.dma_write;
      m_busy  = 1;
      m_phase = 1;
    end
  end

  // ---------------- per-cycle compare + completion log ----------------
  bit g_log[$];
  int dma_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      bit fin;
      fin = m_busy && m_phase >= 2 && bus.mem_ok && !rst;
      chk("mem_read",  32'(bus.mem_read),  32'(m_busy && !m_wr));
      chk("mem_write", 32'(bus.mem_write), 32'(m_busy &&  m_wr));
      chk("mem_drive", 32'(bus.mem_drive), 32'(m_busy &&  m_wr));
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_width", 32'(bus.mem_width), 32'(m_width));
      chk("owner",     32'(bus.owner), 32'(m_own));
      chk("cpu_done",  32'(bus.cpu_done), 32'(fin && !m_own));
      chk("dma_done",  32'(bus.dma_done), 32'(fin &&  m_own));
      chk("cpu_rdata", bus.cpu_rdata, m_crd);
      chk("dma_rdata", bus.dma_rdata, m_drd);
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
      if (bus.cpu_done) g_log.push_back(1'b0);
      if (bus.dma_done) begin g_log.push_back(1'b1); dma_cnt++; end
    end
  end

  // ---------------- directed stimulus ----------------
  bit          ok_pat [64];
  bit          rst_pat[64];
  bit          rd_log [64];
  bit          wr_log [64];
  bit          dr_log [64];
  bit          cd_log [64];
  bit          dd_log [64];
  logic [31:0] addr_log[64];
  bit          auto_drop = 1;

  task automatic set_ok_all();
    for (int i = 0; i < 64; i++) begin ok_pat[i] = 1; rst_pat[i] = 0; end
  endtask

  // Runs n cycles from just after a rising edge; drops a master's req in
  // the cycle after its done when auto_drop is set.
  task automatic run(input int n);
    bit drop_c = 0;
    bit drop_d = 0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ok = ok_pat[i];
      rst = rst_pat[i];
      if (drop_c) bus.cpu_req = 0;
      if (drop_d) bus.dma_req = 0;
      drop_c = 0; drop_d = 0;
      @(negedge clk);
      rd_log[i] = bus.mem_read;  wr_log[i] = bus.mem_write;
      dr_log[i] = bus.mem_drive; addr_log[i] = bus.mem_addr;
      cd_log[i] = bus.cpu_done;  dd_log[i] = bus.dma_done;
      if (auto_drop && bus.cpu_done) drop_c = 1;
      if (auto_drop && bus.dma_done) drop_d = 1;
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  function automatic logic [31:0] pk(input int which, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      case (which)
        0: v = {v[30:0], rd_log[i]};
        1: v = {v[30:0], wr_log[i]};
        2: v = {v[30:0], dr_log[i]};
        3: v = {v[30:0], cd_log[i]};
        default: v = {v[30:0], dd_log[i]};
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] pk_grants(input int start, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++)
      v = {v[30:0], (start + k < g_log.size()) ? g_log[start + k] : 1'b0};
    return v;
  endfunction

  initial begin
    int gs;
    int unstable;
    bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_width = '0; bus.cpu_write = 0;
    bus.dma_req = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_width = '0; bus.dma_write = 0;
    bus.dma_lock = 0; bus.mem_ok = 1; bus.mem_rdata = '0;
    set_ok_all();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    @(negedge clk);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    @(posedge clk); #1;

    // single CPU word read
    bus.cpu_addr = 32'h0300_0010; bus.cpu_width = 2'd2; bus.cpu_write = 0;
    bus.mem_rdata = 32'hDEAD_BEEF; bus.cpu_req = 1;
    run(4);
    chk("t1_read_strobe", pk(0, 4), 32'h6);
    chk("t1_cpu_done",    pk(3, 4), 32'h2);
    chk("t1_cpu_rdata",   bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_dma_done_cnt", 32'(dma_cnt), 32'h0);

    // CPU halfword write, one stall cycle in HOLD
    bus.cpu_addr = 32'h0200_0002; bus.cpu_wdata = 32'h0000_A5A5;
    bus.cpu_width = 2'd1; bus.cpu_write = 1; bus.cpu_req = 1;
    ok_pat[2] = 0;
    run(5);
    set_ok_all();
    chk("t2_write_strobe", pk(1, 5), 32'hE);
    chk("t2_drive",        pk(2, 5), 32'hE);
    chk("t2_cpu_done",     pk(3, 5), 32'h2);

    // both masters continuous, no lock: D D D D C repeating
    bus.cpu_write = 0; bus.cpu_width = 2'd2; bus.cpu_addr = 32'h0300_0100;
    bus.dma_addr = 32'h0100_0000; bus.dma_width = 2'd2; bus.dma_write = 0;
    bus.mem_rdata = 32'h0BAD_F00D;
    auto_drop = 0;
    gs = g_log.size();
    bus.cpu_req = 1; bus.dma_req = 1;
    run(30);
    chk("t3_grant_count", 32'(g_log.size() - gs), 32'd10);
    chk("t3_grants", pk_grants(gs, 10), 32'h3DE);

    // DMA lock: DMA every slot, counter saturates, CPU wins after unlock
    bus.dma_lock = 1;
    gs = g_log.size();
    run(15);
    chk("t4_grants_locked", pk_grants(gs, 5), 32'h1F);
    chk("t4_starve_sat", 32'(dut.starve_cnt), 32'd4);
    bus.dma_lock = 0;
    run(3);
    chk("t4_cpu_after_unlock", 32'(pk_grants(gs + 5, 1)), 32'h0);
    bus.cpu_req = 0; bus.dma_req = 0;
    auto_drop = 1;
    run(2);

    // reset while stalled in HOLD, then re-grant
    bus.cpu_addr = 32'h0300_0020; bus.mem_rdata = 32'h55AA_55AA; bus.cpu_req = 1;
    ok_pat[2] = 0; ok_pat[3] = 0; rst_pat[3] = 1;
    run(8);
    set_ok_all();
    chk("t5_read_strobe", pk(0, 8), 32'h76);
    chk("t5_cpu_done",    pk(3, 8), 32'h2);
    chk("t5_cpu_rdata",   bus.cpu_rdata, 32'h55AA_55AA);

    // long DMA stall with CPU waiting
    bus.cpu_addr = 32'h0300_0030; bus.cpu_req = 1;
    bus.dma_addr = 32'h0100_0040; bus.dma_write = 0; bus.dma_req = 1;
    bus.mem_rdata = 32'h1234_5678;
    for (int i = 2; i <= 11; i++) ok_pat[i] = 0;
    run(17);
    set_ok_all();
    unstable = 0;
    for (int i = 1; i <= 12; i++) if (addr_log[i] !== 32'h0100_0040) unstable++;
    chk("t6_addr_stable", 32'(unstable), 32'h0);
    chk("t6_read_strobe", pk(0, 17), 32'hFFF6);
    chk("t6_dma_done",    pk(4, 17), 32'h10);
    chk("t6_cpu_done",    pk(3, 17), 32'h2);
    chk("t6_dma_rdata",   bus.dma_rdata, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
